ram_arbiter: RTL
================

# ram_arbiter

Shares the single-port synchronous `ram` between the instruction-fetch port and the load/store data port of the core. Each cycle it grants at most one requester and drives the RAM's `addr/din/re/we` from the winner. It routes the RAM's next-cycle `dout` back to the requester that issued the read. When both ports request, a round-robin pointer decides the winner; a programmable priority override is also provided. Per-port saturating stall counters support performance debug.

## Interface
- `AW`, 32, address width, passed straight through to `ram.addr`
- `DW`, 32, data width
- `DATA_PRIO`, 0, when 1 the data port always wins contention and round-robin is disabled
- `CNT_W`, 16, stall counter width
- `clk  in  1  clock, all state rising-edge`
- `resetn  in  1  asynchronous active-low reset`
- `i_req  in  1  fetch read request`
- `i_addr  in  AW  fetch address`
- `i_gnt  out  1  fetch request accepted this cycle`
- `i_rvalid  out  1  fetch read data valid`
- `i_rdata  out  DW  fetch read data`
- `d_req  in  1  data request`
- `d_we  in  1  1 = write, 0 = read`
- `d_addr  in  AW  data address`
- `d_wdata  in  DW  write data`
- `d_gnt  out  1  data request accepted this cycle`
- `d_rvalid  out  1  data read data valid (never for writes)`
- `d_rdata  out  DW  data read data`
- `ram_addr  out  AW`, `ram_din  out  DW`, `ram_re  out  1`, `ram_we  out  1`: to `ram`
- `ram_dout  in  DW  from ram, valid one cycle after ram_re`
- `i_stall_cnt  out  CNT_W  cycles with i_req && !i_gnt, saturating`
- `d_stall_cnt  out  CNT_W  cycles with d_req && !d_gnt, saturating`

## Operation
- Grant logic is combinational from `i_req`, `d_req`, `rr_last`, and `DATA_PRIO`. `i_gnt & d_gnt` is never 1.
- Only one requester: it wins.
- Both requesters, `DATA_PRIO=0`: the port not in `rr_last` wins. `rr_last` updates to the winner only on contended cycles.
- Both requesters, `DATA_PRIO=1`: data wins.
- RAM drive on the winner's cycle:
  - `ram_addr` = winner's address.
  - `ram_re` = fetch win, or data win with `!d_we`.
  - `ram_we` = data win with `d_we`.
  - `ram_din` = `d_wdata`.
- With no grant: `ram_re=ram_we=0`, and `ram_addr/ram_din` hold the data port's values. Do not toggle them needlessly.
- Response tracker, registered: `rsp_pend <= ram_re`, `rsp_own <= winner` (enum I/D).
  - `i_rvalid = rsp_pend && rsp_own==I`.
  - `d_rvalid = rsp_pend && rsp_own==D`.
  - `i_rdata = d_rdata = ram_dout` (unqualified; consumers use `rvalid`).
- No response back-pressure: requesters must accept `rvalid` in the cycle it is asserted.
- Requests are issued strictly in grant order and never reordered. A write granted in cycle N followed by a read of the same address in N+1 returns the new data.
- A requester holds `req` and its fields stable until `gnt`. A dropped request is legal and simply forfeits.
- Stall counters increment by 1 per stalled cycle and saturate at all-ones.

## Timing
- Reset values (async assert, sync-safe deassert): `rr_last=D` (fetch wins first contention), `rsp_pend=0`, `rsp_own=I`, both stall counters 0.
- Outputs under reset follow from these values: `i_rvalid=d_rvalid=0`. Grants stay combinational but must not be relied on.
- Grant latency is 0 cycles (same cycle as `req`). Read latency is exactly 1 cycle from grant to `rvalid`.
- Throughput is one access per cycle. Back-to-back reads from alternating ports under contention give a `rvalid` every cycle, alternating owners.
- Reset asserted while a read is pending: the response is dropped. No `rvalid` appears after `resetn` rises.
- Simultaneous grant and response in the same cycle is normal and independent (pipelined).

## Structure
- Package `frost_mem_pkg` holds:
  - `owner_t` enum {`OWN_I`, `OWN_D`}
  - default `AW`/`DW` constants, shared with `ram` and the core.
- Sub-module `arb2_rr` contains the 2-way round-robin arbiter. Inputs: `req[1:0]`, `prio_en`. Outputs: one-hot `gnt[1:0]`. State: internal `rr_last`.
- Stall counters are inline, not a sub-module.

## Test plan
- Reset, then `i_req=1`, `i_addr=2`, `d_req=0` for one cycle:
  - same cycle: `i_gnt=1`, `ram_re=1`, `ram_addr=2`.
  - next cycle: `i_rvalid=1`, `i_rdata=mem[2]`, `d_rvalid=0`.
- Both ports hold `req` for 4 cycles, with reads at addresses 4 (I) and 8 (D), `DATA_PRIO=0`:
  - grants alternate I, D, I, D.
  - `rvalid` alternates on the next cycles.
  - `i_stall_cnt=2`, `d_stall_cnt=2`.
- Data write 0xDEADBEEF to address 5 in cycle N, then fetch read of address 5 in N+1: `i_rdata=0xDEADBEEF` in N+2. No `rvalid` for the write.
- `DATA_PRIO=1`, both requesting for 3 cycles: `d_gnt` every cycle, `i_gnt=0`, `i_stall_cnt=3`.
- Data read granted, then `resetn` pulsed low before the next edge: after release, `d_rvalid=0` and counters are 0.
- With `CNT_W=4`, hold fetch stalled under `DATA_PRIO=1` for 20 cycles: `i_stall_cnt` saturates at 15.

Source files
------------

// File: rtl/frost_mem_pkg.sv
// Shared memory-subsystem types and default widths for ram, the core and the
// ram_arbiter.
package frost_mem_pkg;

  localparam int unsigned AW_DEF = 32;
  localparam int unsigned DW_DEF = 32;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Maps a one-hot {data, fetch} grant vector to its owner.
  function automatic owner_t gnt_owner(input logic [1:0] gnt);
    return gnt[1] ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/arb2_rr.sv
// Two-way round-robin arbiter with a fixed-priority override.
// req[0]/gnt[0] is the fetch port and req[1]/gnt[1] is the data port.
module arb2_rr
  import frost_mem_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       prio_en,
  output logic [1:0] gnt
);

  owner_t rr_last;

  always_comb begin
    // NOTE: assign every combinational output a default first so that no
    // path through the case statement infers a latch.
    gnt = 2'b00;
    unique case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        if (prio_en) gnt = 2'b10;
        else         gnt = (rr_last == OWN_D) ? 2'b01 : 2'b10;
      end
      default: gnt = 2'b00;
    endcase
  end

  // The pointer only moves when a real choice was made.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (!resetn) begin
      rr_last <= OWN_D;
    end else if ((&req) && !prio_en) begin
      rr_last <= gnt_owner(gnt);
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port synchronous ram between the fetch port and the
// load/store port, routes read data back and keeps per-port stall counters.
module ram_arbiter
  import frost_mem_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int DATA_PRIO = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             resetn,

  input  logic             i_req,
  input  logic [AW-1:0]    i_addr,
  output logic             i_gnt,
  output logic             i_rvalid,
  output logic [DW-1:0]    i_rdata,

  input  logic             d_req,
  input  logic             d_we,
  input  logic [AW-1:0]    d_addr,
  input  logic [DW-1:0]    d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [DW-1:0]    d_rdata,

  output logic [AW-1:0]    ram_addr,
  output logic [DW-1:0]    ram_din,
  output logic             ram_re,
  output logic             ram_we,
  input  logic [DW-1:0]    ram_dout,

  output logic [CNT_W-1:0] i_stall_cnt,
  output logic [CNT_W-1:0] d_stall_cnt
);

  logic [1:0] gnt;
  logic       rsp_pend;
  owner_t     rsp_own;

  arb2_rr u_arb (
    .clk     (clk),
    .resetn  (resetn),
    .req     ({d_req, i_req}),
    .prio_en (DATA_PRIO != 0),
    .gnt     (gnt)
  );

  assign i_gnt = gnt[0];
  assign d_gnt = gnt[1];

  // Idle cycles leave the bus parked on the data port so it does not toggle.
  assign ram_addr = i_gnt ? i_addr : d_addr;
  assign ram_din  = d_wdata;
  assign ram_re   = i_gnt | (d_gnt & ~d_we);
  assign ram_we   = d_gnt & d_we;

  // Response tracker: ram_dout belongs to whoever issued last cycle's read.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_pend <= 1'b0;
      rsp_own  <= OWN_I;
    end else begin
      rsp_pend <= ram_re;
      if (ram_re) rsp_own <= gnt_owner(gnt);
    end
  end

  assign i_rvalid = rsp_pend && (rsp_own == OWN_I);
  assign d_rvalid = rsp_pend && (rsp_own == OWN_D);
  assign i_rdata  = ram_dout;
  assign d_rdata  = ram_dout;

  // Saturating stall counters, held at all-ones once reached.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      i_stall_cnt <= '0;
      d_stall_cnt <= '0;
    end else begin
      if (i_req && !i_gnt && (i_stall_cnt != '1))
        i_stall_cnt <= i_stall_cnt + CNT_W'(1);
      if (d_req && !d_gnt && (d_stall_cnt != '1))
        d_stall_cnt <= d_stall_cnt + CNT_W'(1);
    end
  end

endmodule
